// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, with a memory-ready wait handshake, timeout trap and retire pulse.
module mc_main_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        ALUIWB  = 4'd11,
        JEX     = 4'd12,
        HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur_state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic mem_err_q;
    logic ready;
    logic waiting;
    logic timeout;

    // Gating with reset keeps every ready-qualified enable quiet while reset is held.
    assign ready   = mem_ready & ~reset;
    assign waiting = mem_req & ~ready;
    assign timeout = waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign state   = cur_state;
    assign mem_err = mem_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (waiting) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) mem_err_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = cur_state;
        mem_req    = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        retire     = 1'b0;
        illegal_op = 1'b0;
        unique case (cur_state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = ready;
                pcwrite = ready;
                if (ready) next_state = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_ORI:       next_state = ORIEX;
                    OP_J:         next_state = JEX;
                    default: begin
                        next_state = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (ready) next_state = MEMWB;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ALUIWB;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = 2'b11;
                next_state = ALUIWB;
            end
            ALUIWB: begin
                regwrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
        // A stalled access that has waited too long overrides the normal transition.
        if (timeout) next_state = HALT;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences fetch, decode, execute, memory and writeback over shared memory, ALU and register file.
- Drives datapath mux selects, write enables and the 2-bit aluop consumed by the ALU decoder.
- Adds a memory-ready wait handshake with timeout detection, and a retire pulse.

Parameters:
- MEM_TIMEOUT, 16, number of consecutive wait cycles (mem_req=1, mem_ready=0) that trips mem_err.
- CNT_W, 5, wait-counter width; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction opcode from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access requested.
- iord  output  1  address select: 0 = PC, 1 = ALUOut.
- irwrite, pcwrite, branch, memwrite, regwrite  output  1 each  datapath enables.
- regdst, memtoreg, alusrca  output  1 each  datapath mux selects.
- alusrcb  output  2  00 = reg B, 01 = constant 4, 10 = imm, 11 = imm<<2.
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  output  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- state  output  4  current state, for debug.
- retire  output  1  one-cycle pulse when an instruction completes.
- illegal_op  output  1  one-cycle pulse on an unknown opcode.
- mem_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset: state=FETCH(0), wait counter=0, mem_err=0. All other outputs take their FETCH values; mem_ready is gated, so no write enable fires during reset.
- Outputs are combinational from state, plus mem_ready where noted. Any output not listed for a state is 0.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ORIEX=10
  - ALUIWB=11, JEX=12, HALT=15
- FETCH: mem_req=1, alusrcb=01, irwrite=pcwrite=mem_ready. Stays while mem_ready=0; goes to DECODE on mem_ready=1. Net effect: exactly one PC update per instruction.
- DECODE: alusrcb=11. Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 001101 -> ORIEX
  - 000010 -> JEX
  - anything else -> FETCH, with illegal_op=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR. op is held stable by the IR.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready, else stays.
- MEMWB: regwrite=1, memtoreg=1, retire=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Goes to FETCH with retire=1 on mem_ready, else stays.
- RTYPEEX: alusrca=1, aluop=10 -> RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1, retire=1 -> FETCH.
- BEQEX: alusrca=1, aluop=01, branch=1, pcsrc=01, retire=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10 -> ALUIWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11 -> ALUIWB.
- ALUIWB: regwrite=1, retire=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1, retire=1 -> FETCH.
- Wait counter:
  - Increments (saturating) each cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or when mem_req=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready is still 0, the next state is HALT and mem_err<=1.
  - mem_ready arriving on that same cycle takes priority: normal transition, no error.
- HALT: all enables 0, mem_req=0, mem_err=1. Held until reset.
- Reset asserted in any state, including mid-wait: next state FETCH, counter=0, mem_err=0.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- R-type: reset, op=000000, mem_ready tied 1.
  - Required sequence: FETCH, DECODE, RTYPEEX (aluop=10), RTYPEWB (regwrite=1, regdst=1).
  - retire high in cycle 4; back to FETCH in cycle 5.
- lw with memory waits: op=100011, mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMRD.
  - pcwrite and irwrite pulse exactly once.
  - State path is 0,1,2,3,4; total 5 + 5 wait cycles.
  - MEMWB asserts memtoreg=1 and regwrite=1.
- Branch, immediates, jump, store (mem_ready=1):
  - beq: BEQEX asserts branch=1, pcsrc=01, aluop=01.
  - ori: ORIEX asserts aluop=11, alusrcb=10, then ALUIWB.
  - addi: ADDIEX asserts aluop=00, then ALUIWB.
  - j: JEX asserts pcwrite=1, pcsrc=10.
  - sw: MEMWR asserts memwrite=1, iord=1.
- Illegal opcode: op=111111 -> DECODE returns to FETCH; illegal_op high exactly one cycle; no regwrite or memwrite.
- Timeout: mem_ready held 0 in FETCH with MEM_TIMEOUT=16.
  - After 16 wait cycles, state=15 and mem_err=1; stays there.
  - Pulsing reset returns to state 0 with mem_err=0.
  - Variant: mem_ready=1 exactly on the 16th wait cycle -> DECODE, no error.
- Reset mid-access: assert reset during a MEMWR wait -> next cycle state=0, memwrite=0, counter cleared.
